// File: rtl/goldschmidt_iter_ctrl_if.sv
// Request-side bundle between the divide requester and the iterative Goldschmidt controller.
interface goldschmidt_iter_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic       div_by_zero;
  logic       converged;
  logic [2:0] iter_count;

  modport master (
    output start, abort, a, b,
    input  busy, done, q, div_by_zero, converged, iter_count
  );

  modport slave (
    input  start, abort, a, b,
    output busy, done, q, div_by_zero, converged, iter_count
  );
endinterface

// File: rtl/goldschmidt_iter_ctrl.sv
// Iterative Goldschmidt controller: drives one shared divider stage, feeding xinew back
// until the denominator reaches +1.0, the multiplier collapses to zero, or MAX_ITER runs out.
//
// state | meaning
// IDLE  | waiting for start
// CHECK | screen zero operands, load reciprocal seed
// ISSUE | present a/b/xi to the stage, arm latency counter
// WAIT  | let the stage settle for STG_LAT cycles
// EVAL  | sample stage results, decide exit or next pass
// DONE  | one-cycle done pulse
module goldschmidt_iter_ctrl #(
  parameter int unsigned MAX_ITER = 3,
  parameter int unsigned STG_LAT  = 1,
  parameter logic [7:0]  ONE_VAL  = 8'h38
) (
  input  logic                     clk,
  input  logic                     rst_n,
  goldschmidt_iter_ctrl_if.slave   req,
  output logic [7:0]               stg_a,
  output logic [7:0]               stg_b,
  output logic [7:0]               stg_xi,
  output logic                     stg_valid,
  input  logic [7:0]               stg_c,
  input  logic [7:0]               stg_d,
  input  logic [7:0]               stg_xinew
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_EVAL, S_DONE
  } state_t;

  localparam logic [2:0] MAX_ITER_W = 3'(MAX_ITER);
  localparam logic [3:0] STG_LAT_W  = 4'(STG_LAT);

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] xi_q, xi_d;
  logic [7:0] q_q, q_d;
  logic [2:0] iter_q, iter_d;
  logic [2:0] iter_count_q, iter_count_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       dbz_q, dbz_d;
  logic       conv_q, conv_d;
  logic [2:0] iter_inc;

  // Reciprocal seed exponent: mirrors the exponent around 0111 for the supported range.
  function automatic logic [3:0] seed_exp(input logic [3:0] e);
    logic [3:0] s;
    case (e)
      4'b0100: s = 4'b1010;
      4'b0101: s = 4'b1001;
      4'b0110: s = 4'b1000;
      4'b0111: s = 4'b0111;
      4'b1000: s = 4'b0110;
      4'b1001: s = 4'b0101;
      4'b1010: s = 4'b0100;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  assign iter_inc = iter_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    xi_d         = xi_q;
    q_d          = q_q;
    iter_d       = iter_q;
    iter_count_d = iter_count_q;
    wait_cnt_d   = wait_cnt_q;
    dbz_d        = dbz_q;
    conv_d       = conv_q;

    if (req.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req.start) begin
            a_d          = req.a;
            b_d          = req.b;
            q_d          = 8'h00;
            dbz_d        = 1'b0;
            conv_d       = 1'b0;
            iter_count_d = 3'd0;
            state_d      = S_CHECK;
          end
        end
        S_CHECK: begin
          if (b_q == 8'h00) begin
            q_d     = 8'h00;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else if (a_q == 8'h00) begin
            q_d     = 8'h00;
            state_d = S_DONE;
          end else begin
            xi_d    = {1'b0, seed_exp(b_q[6:3]), 3'b000};
            iter_d  = 3'd0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt_d = STG_LAT_W;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) state_d = S_EVAL;
        end
        S_EVAL: begin
          q_d    = stg_d;
          iter_d = iter_inc;
          // iter_count is loaded on the way into DONE so it is already valid alongside done.
          if (stg_c == ONE_VAL || stg_xinew == 8'h00) begin
            conv_d       = 1'b1;
            iter_count_d = iter_inc;
            state_d      = S_DONE;
          end else if (iter_inc == MAX_ITER_W) begin
            iter_count_d = iter_inc;
            state_d      = S_DONE;
          end else begin
            xi_d    = stg_xinew;
            state_d = S_ISSUE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      xi_q         <= 8'h00;
      q_q          <= 8'h00;
      iter_q       <= 3'd0;
      iter_count_q <= 3'd0;
      wait_cnt_q   <= 4'd0;
      dbz_q        <= 1'b0;
      conv_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      xi_q         <= xi_d;
      q_q          <= q_d;
      iter_q       <= iter_d;
      iter_count_q <= iter_count_d;
      wait_cnt_q   <= wait_cnt_d;
      dbz_q        <= dbz_d;
      conv_q       <= conv_d;
    end
  end

  assign req.busy        = (state_q != S_IDLE);
  assign req.done        = (state_q == S_DONE);
  assign req.q           = q_q;
  assign req.div_by_zero = dbz_q;
  assign req.converged   = conv_q;
  assign req.iter_count  = iter_count_q;

  assign stg_a     = a_q;
  assign stg_b     = b_q;
  assign stg_xi    = xi_q;
  assign stg_valid = (state_q == S_ISSUE) || (state_q == S_WAIT);

endmodule

// File: doc/goldschmidt_iter_ctrl.md
Name: goldschmidt_iter_ctrl

Overview:
- Sequential controller that runs one shared Goldschmidt divider stage iteratively, replacing the fixed three-stage combinational chain.
- Captures A/B on a start handshake and screens zero operands.
- Generates the reciprocal seed xi from B's exponent, feeds the stage, and feeds back xinew until convergence or MAX_ITER, then returns Q with a one-cycle done pulse.
- Sits between the top-level divide request and a single divider-stage instance (ports stg_*).

Parameters:
MAX_ITER, 3, maximum stage evaluations per divide (1..7)
STG_LAT, 1, wait cycles after issuing operands before sampling stage outputs (1..15)
ONE_VAL, 8'h38, stage C (denominator) value treated as converged (+1.0: sign 0, exp 0111, mant 000)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE with no done pulse
a  in  8  dividend, format {sign, exp[3:0], mant[2:0]} with hidden 1
b  in  8  divisor, same format
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when q is valid
q  out  8  quotient; held until the next accepted start
div_by_zero  out  1  set with done when b==0; cleared on the next accepted start
converged  out  1  set with done when exit was by convergence rather than iteration limit
iter_count  out  3  number of stage evaluations used for the last divide
stg_a  out  8  dividend to stage (registered a)
stg_b  out  8  divisor to stage (registered b)
stg_xi  out  8  current multiplier xi to stage
stg_valid  out  1  high in ISSUE and WAIT
stg_c  in  8  stage denominator result D_i (stage output C)
stg_d  in  8  stage numerator result N_i (stage output D)
stg_xinew  in  8  stage next-multiplier result

Behaviour:
- Reset: state=IDLE; all outputs and internal registers 0.
- States: IDLE, CHECK, ISSUE, WAIT, EVAL, DONE.
- IDLE
  - On start=1: capture a, b; clear q, div_by_zero, converged, iter_count; go to CHECK.
- CHECK (1 cycle)
  - b==8'h00: q=0, div_by_zero=1, go to DONE.
  - Else a==8'h00: q=0, go to DONE.
  - Else load xi = {1'b0, seed(b[6:3]), 3'b000}, iter=0, go to ISSUE.
- Seed table (exp -> seed exp):
  - 0111->0111, 1000->0110, 1001->0101, 1010->0100, 0110->1000, 0101->1001, 0100->1010.
  - Any other exponent -> 0000; this is legal, and the loop still runs.
- ISSUE (1 cycle): stg_valid=1; load wait counter = STG_LAT; go to WAIT.
- WAIT: stg_valid=1; decrement the counter; go to EVAL when the counter reaches 1 (i.e. exactly STG_LAT cycles).
- EVAL (1 cycle)
  - q <= stg_d; iter <= iter+1.
  - If stg_c==ONE_VAL or stg_xinew==8'h00: converged=1, go to DONE.
  - Else if iter+1==MAX_ITER: go to DONE.
  - Else xi <= stg_xinew, go to ISSUE.
- DONE (1 cycle): done=1; iter_count <= iter; go to IDLE. A start in DONE is ignored.
- stg_a, stg_b, stg_xi are stable from ISSUE through EVAL of each iteration.
- Latency, start-sampling edge to done cycle:
  - Zero operand: 2 clocks.
  - Otherwise: 1 + n*(2+STG_LAT) + 1 clocks for n evaluations.
  - Defaults, no early exit: 11 clocks.
- Boundary conditions:
  - start while busy: ignored, with no queuing.
  - abort has priority over every transition except reset. It forces IDLE in the next cycle, with no done, and q/flags keep their prior values.
  - abort and start both high in IDLE: abort wins and the start is dropped.
  - Reset mid-operation: immediate clear to the reset state.
  - b==0 and a==0 together: div_by_zero=1, q=0.
  - Convergence and iteration limit in the same EVAL: converged=1.

Test Plan:
- a=8'h40, b=8'h00, start pulse -> done 2 clocks later; q=8'h00, div_by_zero=1, iter_count=0, stg_valid never high.
- a=8'h00, b=8'h40 -> done 2 clocks later; q=8'h00, div_by_zero=0, converged=0.
- b=8'h40 (exp 1000); stub stage with stg_c=8'h3C, stg_xinew=8'h2A, stg_d=8'h45 -> first stg_xi=8'h30, second and third stg_xi=8'h2A; done 11 clocks after start; q=8'h45, iter_count=3, converged=0.
- Stub returns stg_c=8'h38 on the first EVAL -> done 5 clocks after start; iter_count=1, converged=1; a start asserted during DONE is ignored (busy stays low in the next cycle).
- STG_LAT=3, MAX_ITER=2, non-converging stub -> stg_valid high for 4 consecutive cycles per iteration; done 12 clocks after start.
- abort asserted in the second WAIT -> IDLE next cycle, no done pulse, q unchanged. Separately, rst_n low mid-EVAL -> all outputs 0 asynchronously; a fresh start afterwards completes normally.
